// File: rtl/regbus_pkg.sv
// Shared definitions for the two-master register bus arbiter:
// state encoding, bus widths, register map and the round-robin pick.
package regbus_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] GPA_OE    = 3'd0;
    localparam logic [ADDR_W-1:0] GPA_ODATA = 3'd1;
    localparam logic [ADDR_W-1:0] GPA_IDATA = 3'd2;
    localparam logic [ADDR_W-1:0] LED_NR0   = 3'd3;
    localparam logic [ADDR_W-1:0] LED_NR1   = 3'd4;
    localparam logic [ADDR_W-1:0] UART_DATA = 3'd5;
    localparam logic [ADDR_W-1:0] UART_STAT = 3'd6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Returns the winning master index; on a tie the one not granted last wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return ~last;
        end
        return req1;
    endfunction

endpackage

// File: rtl/regbus_arb.sv
// Two-master round-robin arbiter/sequencer for the 8-entry register bus.
// Each transaction runs IDLE -> ISSUE -> CAPTURE -> DONE with all outputs registered.
//
// state   | meaning
// IDLE    | wait for a request, latch winner's command
// ISSUE   | single-cycle reg_we or reg_re strobe
// CAPTURE | sample reg_rdata for reads
// DONE    | one-cycle ack to the granted master
module regbus_arb #(
    parameter int ADDR_W = regbus_pkg::ADDR_W,
    parameter int DATA_W = regbus_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              reg_we,
    output logic              reg_re,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy
);
    import regbus_pkg::*;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q, gnt_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              busy_q, busy_d;
    logic              win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            cmd_wr_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            cmd_wr_q     <= cmd_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            re_q         <= re_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    // Strobes and acks are computed one state early so they appear registered in their own state.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        cmd_wr_d     = cmd_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        re_d         = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        win          = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    win      = rr_pick(m0_req, m1_req, last_grant_q);
                    gnt_d    = win;
                    cmd_wr_d = win ? m1_wr    : m0_wr;
                    addr_d   = win ? m1_addr  : m0_addr;
                    wdata_d  = win ? m1_wdata : m0_wdata;
                    we_d     = cmd_wr_d;
                    re_d     = ~cmd_wr_d;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!cmd_wr_q) begin
                    if (gnt_q) rdata1_d = reg_rdata;
                    else       rdata0_d = reg_rdata;
                end
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
                state_d = DONE;
            end
            DONE: begin
                last_grant_d = gnt_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign m0_ack    = ack0_q;
    assign m1_ack    = ack1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_regbus_arb.sv
// Directed bench for regbus_arb: hand-computed expectations checked at negedges.
module tb_regbus_arb;
    import regbus_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       m0_req, m0_wr, m0_ack;
    logic [2:0] m0_addr;
    logic [7:0] m0_wdata, m0_rdata;
    logic       m1_req, m1_wr, m1_ack;
    logic [2:0] m1_addr;
    logic [7:0] m1_wdata, m1_rdata;
    logic       reg_we, reg_re, busy;
    logic [2:0] reg_addr;
    logic [7:0] reg_wdata, reg_rdata;
    logic [7:0] rf [8];

    int total = 0;
    int bad   = 0;

    regbus_arb dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    assign reg_rdata = rf[reg_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("we_re_excl", 32'(reg_we & reg_re), 0);
            chk("ack_excl", 32'(m0_ack & m1_ack), 0);
        end
    end

    // Entered at a negedge in IDLE with the request set up; returns at the negedge of the ack cycle.
    task automatic expect_txn(input bit who, input bit wr, input logic [2:0] addr,
                              input logic [7:0] wdata, input logic [7:0] rd, input bit drop);
        @(negedge clk);
        chk("issue_we", 32'(reg_we), 32'(wr));
        chk("issue_re", 32'(reg_re), 32'(!wr));
        chk("issue_addr", 32'(reg_addr), 32'(addr));
        chk("issue_wdata", 32'(reg_wdata), 32'(wdata));
        chk("issue_busy", 32'(busy), 1);
        chk("issue_ack0", 32'(m0_ack), 0);
        chk("issue_ack1", 32'(m1_ack), 0);
        @(negedge clk);
        chk("capt_we", 32'(reg_we), 0);
        chk("capt_re", 32'(reg_re), 0);
        @(negedge clk);
        chk("done_ack0", 32'(m0_ack), 32'(!who));
        chk("done_ack1", 32'(m1_ack), 32'(who));
        if (!wr) begin
            if (who) chk("done_m1_rdata", 32'(m1_rdata), 32'(rd));
            else     chk("done_m0_rdata", 32'(m0_rdata), 32'(rd));
        end
        if (drop) begin
            if (who) m1_req = 1'b0;
            else     m0_req = 1'b0;
        end
    endtask

    initial begin
        rf[0] = 8'h00; rf[1] = 8'h11; rf[2] = 8'h3C; rf[3] = 8'h47;
        rf[4] = 8'h22; rf[5] = 8'h99; rf[6] = 8'h81; rf[7] = 8'hE7;
        rst_n = 1'b0;
        m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_we", 32'(reg_we), 0);
        chk("rst_re", 32'(reg_re), 0);
        chk("rst_addr", 32'(reg_addr), 0);
        chk("rst_wdata", 32'(reg_wdata), 0);
        chk("rst_ack0", 32'(m0_ack), 0);
        chk("rst_ack1", 32'(m1_ack), 0);
        chk("rst_rdata0", 32'(m0_rdata), 0);
        chk("rst_rdata1", 32'(m1_rdata), 0);
        chk("rst_busy", 32'(busy), 0);

        // Contention straight out of reset: m0 wins first, then strict alternation
        m0_req = 1; m0_wr = 0; m0_addr = UART_STAT; m0_wdata = 8'h00;
        m1_req = 1; m1_wr = 1; m1_addr = LED_NR1;   m1_wdata = 8'h5A;
        rst_n = 1'b1;
        expect_txn(1'b0, 1'b0, 3'd6, 8'h00, 8'h81, 1'b0);
        @(negedge clk);
        chk("gap1_busy", 32'(busy), 0);
        expect_txn(1'b1, 1'b1, 3'd4, 8'h5A, 8'h00, 1'b0);
        @(negedge clk);
        expect_txn(1'b0, 1'b0, 3'd6, 8'h00, 8'h81, 1'b1);
        @(negedge clk);
        expect_txn(1'b1, 1'b1, 3'd4, 8'h5A, 8'h00, 1'b1);
        @(negedge clk);
        chk("cont_idle_busy", 32'(busy), 0);

        // Single write from m0
        m0_req = 1; m0_wr = 1; m0_addr = GPA_ODATA; m0_wdata = 8'hA5;
        expect_txn(1'b0, 1'b1, 3'd1, 8'hA5, 8'h00, 1'b1);
        chk("wr_m0_rdata_kept", 32'(m0_rdata), 'h81);
        @(negedge clk);
        chk("wr_ack_gone", 32'(m0_ack), 0);

        // Single read from m1
        m1_req = 1; m1_wr = 0; m1_addr = GPA_IDATA; m1_wdata = 8'h00;
        expect_txn(1'b1, 1'b0, 3'd2, 8'h00, 8'h3C, 1'b1);
        chk("rd_m0_rdata_kept", 32'(m0_rdata), 'h81);
        @(negedge clk);
        chk("rd_m1_rdata_held", 32'(m1_rdata), 'h3C);

        // Held request: three back-to-back m0 reads, 4 cycles apart
        m0_req = 1; m0_wr = 0; m0_addr = LED_NR0; m0_wdata = 8'h00;
        expect_txn(1'b0, 1'b0, 3'd3, 8'h00, 8'h47, 1'b0);
        @(negedge clk);
        chk("held_gap1_re", 32'(reg_re), 0);
        chk("held_gap1_busy", 32'(busy), 0);
        expect_txn(1'b0, 1'b0, 3'd3, 8'h00, 8'h47, 1'b0);
        @(negedge clk);
        chk("held_gap2_busy", 32'(busy), 0);
        expect_txn(1'b0, 1'b0, 3'd3, 8'h00, 8'h47, 1'b1);
        @(negedge clk);
        chk("held_no_ack1", 32'(m1_ack), 0);

        // Command inputs change right after the IDLE latch edge
        m0_req = 1; m0_wr = 1; m0_addr = 3'd4; m0_wdata = 8'h11;
        @(posedge clk);
        #1;
        m0_addr = 3'd7; m0_wdata = 8'hFF;
        @(negedge clk);
        chk("latch_addr", 32'(reg_addr), 4);
        chk("latch_wdata", 32'(reg_wdata), 'h11);
        chk("latch_we", 32'(reg_we), 1);
        @(negedge clk);
        @(negedge clk);
        chk("latch_ack0", 32'(m0_ack), 1);
        m0_req = 0;
        @(negedge clk);

        // Reset during ISSUE, then pending m1 request is served
        m1_req = 1; m1_wr = 0; m1_addr = UART_DATA; m1_wdata = 8'h00;
        @(negedge clk);
        chk("pre_rst_re", 32'(reg_re), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_re", 32'(reg_re), 0);
        chk("mid_rst_we", 32'(reg_we), 0);
        chk("mid_rst_addr", 32'(reg_addr), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rdata1", 32'(m1_rdata), 0);
        chk("mid_rst_rdata0", 32'(m0_rdata), 0);
        @(negedge clk);
        chk("rst_no_ack1", 32'(m1_ack), 0);
        @(negedge clk);
        chk("rst_no_ack1b", 32'(m1_ack), 0);
        rst_n = 1'b1;
        expect_txn(1'b1, 1'b0, 3'd5, 8'h00, 8'h99, 1'b1);
        @(negedge clk);
        chk("end_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
